// File: rtl/riscv_pipe_skid_stage.sv
// riscv_pipe_skid_stage: pipeline register stage between two RISC-V pipe stages.
// SKID=1 gives a 2-entry skid buffer whose in_ready comes straight from a flop;
// SKID=0 gives a single register with a combinational in_ready.
// flush squashes every held entry; CLEAR_DATA zeroes emptied payloads so a
// bubble never carries a stale write enable.
module riscv_pipe_skid_stage #(
    parameter int WIDTH      = 72,
    parameter int SKID       = 1,
    parameter int CLEAR_DATA = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    logic             r_main_valid;
    logic [WIDTH-1:0] r_main_data;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic [1:0]       r_occ;

    logic             w_accept;
    logic             w_consume;
    logic             w_main_valid_nxt;
    logic [WIDTH-1:0] w_main_data_nxt;
    logic             w_skid_valid_nxt;
    logic [WIDTH-1:0] w_skid_data_nxt;

    // in_ready: registered in skid mode, pass-through of downstream ready otherwise
    generate
        if (SKID != 0) begin : g_ready_skid
            assign in_ready = !r_skid_valid;
        end else begin : g_ready_pass
            assign in_ready = !r_main_valid || out_ready;
        end
    endgenerate

    assign w_accept  = in_valid && in_ready;
    assign w_consume = r_main_valid && out_ready;

    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;
    assign occupancy = r_occ;

    // Next-state selection for main and skid entries; flush overrides everything
    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_main_data_nxt  = r_main_data;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_data_nxt  = r_skid_data;
        if (flush) begin
            w_main_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
            if (CLEAR_DATA != 0) begin
                w_main_data_nxt = '0;
                w_skid_data_nxt = '0;
            end
        end else if (SKID != 0) begin
            if (r_skid_valid && w_consume) begin
                // in_ready is low here, so no accept can coincide with the refill
                w_main_data_nxt  = r_skid_data;
                w_skid_valid_nxt = 1'b0;
                if (CLEAR_DATA != 0) begin
                    w_skid_data_nxt = '0;
                end
            end else if (w_accept && (!r_main_valid || w_consume)) begin
                w_main_valid_nxt = 1'b1;
                w_main_data_nxt  = in_data;
            end else if (w_accept) begin
                w_skid_valid_nxt = 1'b1;
                w_skid_data_nxt  = in_data;
            end else if (w_consume) begin
                w_main_valid_nxt = 1'b0;
                if (CLEAR_DATA != 0) begin
                    w_main_data_nxt = '0;
                end
            end
        end else begin
            if (w_accept) begin
                w_main_valid_nxt = 1'b1;
                w_main_data_nxt  = in_data;
            end else if (w_consume) begin
                w_main_valid_nxt = 1'b0;
                if (CLEAR_DATA != 0) begin
                    w_main_data_nxt = '0;
                end
            end
        end
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_occ        <= '0;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_main_data  <= w_main_data_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_data  <= w_skid_data_nxt;
            r_occ        <= {1'b0, w_main_valid_nxt} + {1'b0, w_skid_valid_nxt};
        end
    end

endmodule

// File: tb/tb_riscv_pipe_skid_stage.sv
// Testbench for riscv_pipe_skid_stage: directed scenarios plus a randomized
// run checked against a queue model, on one SKID=1 and one SKID=0 instance.
module tb_riscv_pipe_skid_stage;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;

    logic       v1 = 1'b0, ir1, ov1, or1 = 1'b0;
    logic [7:0] d1 = '0, od1;
    logic [1:0] occ1;

    logic       v0 = 1'b0, ir0, ov0, or0 = 1'b0;
    logic [7:0] d0 = '0, od0;
    logic [1:0] occ0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] q1[$];
    logic [7:0] q0[$];

    always #5 clk = ~clk;

    riscv_pipe_skid_stage #(.WIDTH(8), .SKID(1), .CLEAR_DATA(1)) u_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(v1), .in_ready(ir1), .in_data(d1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .occupancy(occ1)
    );

    riscv_pipe_skid_stage #(.WIDTH(8), .SKID(0), .CLEAR_DATA(1)) u_flat (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(v0), .in_ready(ir0), .in_data(d0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0), .occupancy(occ0)
    );

    // Advance to the next falling edge (inputs are driven there, outputs checked #1 later)
    task automatic next_cycle();
        @(negedge clk);
    endtask

    // Empty both stages with a one-cycle flush and park inputs idle
    task automatic drain();
        next_cycle();
        v1 = 0; v0 = 0; or1 = 0; or0 = 0; flush = 1;
        next_cycle();
        flush = 0;
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (ov1 !== 1'b0) $display("FAIL reset_ov1 got %b want 0", ov1); else n_pass++;
        n_checks++; if (occ1 !== 2'd0) $display("FAIL reset_occ1 got %0d want 0", occ1); else n_pass++;
        n_checks++; if (od1 !== 8'h00) $display("FAIL reset_od1 got %h want 00", od1); else n_pass++;
        n_checks++; if (ir1 !== 1'b1) $display("FAIL reset_ir1 got %b want 1", ir1); else n_pass++;
        n_checks++; if (ir0 !== 1'b1) $display("FAIL reset_ir0 got %b want 1", ir0); else n_pass++;
        n_checks++; if (ov0 !== 1'b0) $display("FAIL reset_ov0 got %b want 0", ov0); else n_pass++;
        next_cycle();
        next_cycle();
        rst = 0;
    endtask

    task automatic test_stream();
        logic [7:0] seq [4];
        seq[0] = 8'h01; seq[1] = 8'h02; seq[2] = 8'h03; seq[3] = 8'h00;
        drain();
        or1 = 1; v1 = 1; d1 = seq[0];
        #1;
        n_checks++; if (ir1 !== 1'b1) $display("FAIL stream_ir0 got %b want 1", ir1); else n_pass++;
        for (int i = 1; i < 4; i++) begin
            next_cycle();
            v1 = (i < 3); d1 = seq[i];
            #1;
            n_checks++; if (od1 !== seq[i-1]) $display("FAIL stream_data%0d got %h want %h", i, od1, seq[i-1]); else n_pass++;
            n_checks++; if (occ1 !== 2'd1) $display("FAIL stream_occ%0d got %0d want 1", i, occ1); else n_pass++;
            n_checks++; if (ir1 !== 1'b1) $display("FAIL stream_ir%0d got %b want 1", i, ir1); else n_pass++;
        end
        next_cycle();
        #1;
        n_checks++; if (ov1 !== 1'b0) $display("FAIL stream_end_ov got %b want 0", ov1); else n_pass++;
        n_checks++; if (od1 !== 8'h00) $display("FAIL stream_bubble_data got %h want 00", od1); else n_pass++;
    endtask

    task automatic test_backpressure();
        drain();
        or1 = 0; v1 = 1; d1 = 8'hA1;
        next_cycle();
        d1 = 8'hA2;
        #1;
        n_checks++; if (ir1 !== 1'b1) $display("FAIL bp_ir_one got %b want 1", ir1); else n_pass++;
        next_cycle();
        v1 = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++; if (occ1 !== 2'd2) $display("FAIL bp_occ_full%0d got %0d want 2", i, occ1); else n_pass++;
            n_checks++; if (ir1 !== 1'b0) $display("FAIL bp_ir_full%0d got %b want 0", i, ir1); else n_pass++;
            n_checks++; if (od1 !== 8'hA1) $display("FAIL bp_hold%0d got %h want a1", i, od1); else n_pass++;
            next_cycle();
        end
        or1 = 1;
        #1;
        n_checks++; if (od1 !== 8'hA1) $display("FAIL bp_first got %h want a1", od1); else n_pass++;
        next_cycle();
        #1;
        n_checks++; if (od1 !== 8'hA2) $display("FAIL bp_second got %h want a2", od1); else n_pass++;
        n_checks++; if (ir1 !== 1'b1) $display("FAIL bp_ir_reopen got %b want 1", ir1); else n_pass++;
        n_checks++; if (occ1 !== 2'd1) $display("FAIL bp_occ_one got %0d want 1", occ1); else n_pass++;
        next_cycle();
        #1;
        n_checks++; if (ov1 !== 1'b0) $display("FAIL bp_empty got %b want 0", ov1); else n_pass++;
    endtask

    task automatic test_flush_full();
        drain();
        or1 = 0; v1 = 1; d1 = 8'hB1;
        next_cycle();
        d1 = 8'hB2;
        next_cycle();
        flush = 1; v1 = 1; d1 = 8'hFF; or1 = 1;
        next_cycle();
        flush = 0; v1 = 0; or1 = 0;
        #1;
        n_checks++; if (ov1 !== 1'b0) $display("FAIL flush_ov got %b want 0", ov1); else n_pass++;
        n_checks++; if (occ1 !== 2'd0) $display("FAIL flush_occ got %0d want 0", occ1); else n_pass++;
        n_checks++; if (od1 !== 8'h00) $display("FAIL flush_data got %h want 00", od1); else n_pass++;
        n_checks++; if (ir1 !== 1'b1) $display("FAIL flush_ir got %b want 1", ir1); else n_pass++;
        next_cycle();
        #1;
        n_checks++; if (ov1 !== 1'b0 || od1 === 8'hFF) $display("FAIL flush_leak got ov=%b d=%h want ov=0", ov1, od1); else n_pass++;
    endtask

    task automatic test_skid0();
        drain();
        or0 = 0; v0 = 1; d0 = 8'h11;
        #1;
        n_checks++; if (ir0 !== 1'b1) $display("FAIL flat_ir_empty got %b want 1", ir0); else n_pass++;
        next_cycle();
        d0 = 8'h55;
        #1;
        n_checks++; if (ir0 !== 1'b0) $display("FAIL flat_ir_full got %b want 0", ir0); else n_pass++;
        n_checks++; if (od0 !== 8'h11) $display("FAIL flat_head got %h want 11", od0); else n_pass++;
        next_cycle();
        or0 = 1;
        #1;
        n_checks++; if (od0 !== 8'h11) $display("FAIL flat_hold got %h want 11", od0); else n_pass++;
        n_checks++; if (ir0 !== 1'b1) $display("FAIL flat_ir_ready got %b want 1", ir0); else n_pass++;
        next_cycle();
        v0 = 0;
        #1;
        n_checks++; if (od0 !== 8'h55) $display("FAIL flat_replace got %h want 55", od0); else n_pass++;
        n_checks++; if (occ0 !== 2'd1) $display("FAIL flat_occ got %0d want 1", occ0); else n_pass++;
        next_cycle();
        #1;
        n_checks++; if (ov0 !== 1'b0 || od0 !== 8'h00) $display("FAIL flat_empty got ov=%b d=%h want ov=0 d=00", ov0, od0); else n_pass++;
    endtask

    task automatic test_async_reset();
        drain();
        or1 = 0; v1 = 1; d1 = 8'hC1;
        next_cycle();
        d1 = 8'hC2;
        next_cycle();
        v1 = 0;
        #1;
        n_checks++; if (occ1 !== 2'd2) $display("FAIL areset_pre_occ got %0d want 2", occ1); else n_pass++;
        #1 rst = 1;
        #1;
        n_checks++; if (ov1 !== 1'b0) $display("FAIL areset_ov got %b want 0", ov1); else n_pass++;
        n_checks++; if (occ1 !== 2'd0) $display("FAIL areset_occ got %0d want 0", occ1); else n_pass++;
        n_checks++; if (od1 !== 8'h00) $display("FAIL areset_data got %h want 00", od1); else n_pass++;
        n_checks++; if (ir1 !== 1'b1) $display("FAIL areset_ir got %b want 1", ir1); else n_pass++;
        next_cycle();
        rst = 0; v1 = 1; d1 = 8'hD1;
        next_cycle();
        v1 = 0;
        #1;
        n_checks++; if (od1 !== 8'hD1 || occ1 !== 2'd1) $display("FAIL areset_after got d=%h occ=%0d want d1/1", od1, occ1); else n_pass++;
    endtask

    task automatic test_random();
        bit acc1, con1, acc0, con0, exp_ir1, exp_ir0;
        logic [7:0] exp_d1, exp_d0;
        int errs = 0;
        drain();
        q1.delete();
        q0.delete();
        for (int c = 0; c < 20000; c++) begin
            next_cycle();
            v1 = $urandom_range(0, 1); d1 = 8'($urandom); or1 = ($urandom_range(0, 3) != 0);
            v0 = $urandom_range(0, 1); d0 = 8'($urandom); or0 = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 31) == 0);
            #1;
            exp_ir1 = (q1.size() < 2);
            exp_ir0 = (q0.size() == 0) || or0;
            exp_d1  = (q1.size() > 0) ? q1[0] : 8'h00;
            exp_d0  = (q0.size() > 0) ? q0[0] : 8'h00;
            if (errs < 20) begin
                n_checks++; if (ir1 !== exp_ir1) begin $display("FAIL rnd_ir1 c=%0d got %b want %b", c, ir1, exp_ir1); errs++; end else n_pass++;
                n_checks++; if (ov1 !== (q1.size() > 0)) begin $display("FAIL rnd_ov1 c=%0d got %b want %0d", c, ov1, q1.size() > 0); errs++; end else n_pass++;
                n_checks++; if (od1 !== exp_d1) begin $display("FAIL rnd_od1 c=%0d got %h want %h", c, od1, exp_d1); errs++; end else n_pass++;
                n_checks++; if (occ1 !== 2'(q1.size())) begin $display("FAIL rnd_occ1 c=%0d got %0d want %0d", c, occ1, q1.size()); errs++; end else n_pass++;
                n_checks++; if (ir0 !== exp_ir0) begin $display("FAIL rnd_ir0 c=%0d got %b want %b", c, ir0, exp_ir0); errs++; end else n_pass++;
                n_checks++; if (ov0 !== (q0.size() > 0)) begin $display("FAIL rnd_ov0 c=%0d got %b want %0d", c, ov0, q0.size() > 0); errs++; end else n_pass++;
                n_checks++; if (od0 !== exp_d0) begin $display("FAIL rnd_od0 c=%0d got %h want %h", c, od0, exp_d0); errs++; end else n_pass++;
                n_checks++; if (occ0 !== 2'(q0.size())) begin $display("FAIL rnd_occ0 c=%0d got %0d want %0d", c, occ0, q0.size()); errs++; end else n_pass++;
            end
            acc1 = v1 && exp_ir1;
            con1 = (q1.size() > 0) && or1;
            acc0 = v0 && exp_ir0;
            con0 = (q0.size() > 0) && or0;
            if (flush) begin
                q1.delete();
                q0.delete();
            end else begin
                if (con1) void'(q1.pop_front());
                if (acc1) q1.push_back(d1);
                if (con0) void'(q0.pop_front());
                if (acc0) q0.push_back(d0);
            end
        end
        flush = 0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_full();
        test_skid0();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
